// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared definitions for the RISC-V memory responder:
//   - BUS_WIDTH_DEF : default data/address width of both core buses.
//   - WORD_ALIGN    : value the low two address bits must hold for a word access.
//   - err_cause_e   : classification of a rejected access.
//   - word_index()  : byte address -> word index for a power-of-two array depth.
package riscv_mem_pkg;

    localparam int         BUS_WIDTH_DEF = 32;
    localparam logic [1:0] WORD_ALIGN    = 2'b00;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_MISALIGN_D  = 2'd1,
        ERR_MISALIGN_I  = 2'd2,
        ERR_RW_CONFLICT = 2'd3
    } err_cause_e;

    // Drops the byte offset and keeps only log2(depth) index bits, so
    // addresses past the array alias back onto it (depth is a power of two).
    function automatic logic [31:0] word_index(input logic [63:0] byte_addr,
                                               input int unsigned depth);
        return 32'((byte_addr >> 2) & 64'(depth - 1));
    endfunction

endpackage

// File: rtl/riscv_ram.sv
// riscv_ram
//   Single-write-port word array. Contents are never reset.
//   ASYNC_READ=1 : rdata follows raddr combinationally (re and rst unused).
//   ASYNC_READ=0 : rdata is registered on a clock edge with re=1 and holds
//                  otherwise; the read register is cleared by rst.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata  write port, written on the rising edge
//   re, raddr, rdata  read port
module riscv_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter bit ASYNC_READ = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (ASYNC_READ) begin : g_async
            assign rdata = mem[raddr];
            logic unused_sync;
            assign unused_sync = re ^ rst;
        end else begin : g_sync
            logic [WIDTH-1:0] rd_q;
            logic [WIDTH-1:0] rd_d;

            always_comb begin
                rd_d = rd_q;
                if (re) begin
                    rd_d = mem[raddr];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign rdata = rd_q;
        end
    endgenerate

endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder
//   Memory-side responder for the pipelined RISC-V core.
//   Instruction port: combinational fetch at iaddr, program-load writes on iwr.
//   Data port: stores on wr, loads on re with registered rdata and rvalid.
//   Misaligned accesses and wr+re conflicts are rejected: err pulses for one
//   cycle and the first offending address is held in err_addr/err_sticky.
//   load_count/store_count count accepted accesses and saturate at all-ones.
//
//   Load protocol: a load presented in cycle N (re=1, wr=0, aligned) returns
//   rdata with rvalid=1 during cycle N+1 only; there is no backpressure.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   iwr, iaddr, iwdata, idata  instruction port
//   wr, re, addr, wdata        data request
//   rdata, rvalid              load response
//   err, err_addr, err_sticky  error reporting
//   load_count, store_count    saturating access counters
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iwr,
    input  logic [BUS_WIDTH-1:0] iaddr,
    input  logic [BUS_WIDTH-1:0] iwdata,
    output logic [BUS_WIDTH-1:0] idata,
    input  logic                 wr,
    input  logic                 re,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0] wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 rvalid,
    output logic                 err,
    output logic [BUS_WIDTH-1:0] err_addr,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] load_count,
    output logic [CNT_WIDTH-1:0] store_count
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [IAW-1:0] i_idx;
    logic [DAW-1:0] d_idx;

    assign i_idx = IAW'(word_index(64'(iaddr), IMEM_WORDS));
    assign d_idx = DAW'(word_index(64'(addr), DMEM_WORDS));

    // Request classification
    logic       i_mis;
    logic       d_mis;
    logic       rw_conflict;
    logic       i_we;
    logic       st_ok;
    logic       ld_ok;
    err_cause_e err_cause;

    assign i_mis       = iwr && (iaddr[1:0] != WORD_ALIGN);
    assign d_mis       = (wr || re) && (addr[1:0] != WORD_ALIGN);
    assign rw_conflict = wr && re && !d_mis;
    assign i_we        = iwr && !i_mis;
    // A wr+re conflict still performs the store; only the load is dropped.
    assign st_ok       = wr && !d_mis;
    assign ld_ok       = re && !wr && !d_mis;

    // Data-port causes override the instruction-port cause, so that when both
    // ports fault together the data address is the one captured.
    always_comb begin
        err_cause = ERR_NONE;
        if (i_mis) begin
            err_cause = ERR_MISALIGN_I;
        end
        if (rw_conflict) begin
            err_cause = ERR_RW_CONFLICT;
        end
        if (d_mis) begin
            err_cause = ERR_MISALIGN_D;
        end
    end

    // Arrays
    riscv_ram #(
        .WIDTH      (BUS_WIDTH),
        .DEPTH      (IMEM_WORDS),
        .ASYNC_READ (1'b1)
    ) u_imem (
        .clk   (clk),
        .rst   (reset),
        .we    (i_we),
        .waddr (i_idx),
        .wdata (iwdata),
        .re    (1'b0),
        .raddr (i_idx),
        .rdata (idata)
    );

    riscv_ram #(
        .WIDTH      (BUS_WIDTH),
        .DEPTH      (DMEM_WORDS),
        .ASYNC_READ (1'b0)
    ) u_dmem (
        .clk   (clk),
        .rst   (reset),
        .we    (st_ok),
        .waddr (d_idx),
        .wdata (wdata),
        .re    (ld_ok),
        .raddr (d_idx),
        .rdata (rdata)
    );

    // Status registers
    logic                 rvalid_q,      rvalid_d;
    logic                 err_q,         err_d;
    logic [BUS_WIDTH-1:0] err_addr_q,    err_addr_d;
    logic                 err_sticky_q,  err_sticky_d;
    logic [CNT_WIDTH-1:0] load_count_q,  load_count_d;
    logic [CNT_WIDTH-1:0] store_count_q, store_count_d;

    always_comb begin
        rvalid_d      = ld_ok;
        err_d         = (err_cause != ERR_NONE);
        err_addr_d    = err_addr_q;
        err_sticky_d  = err_sticky_q;
        load_count_d  = load_count_q;
        store_count_d = store_count_q;

        if ((err_cause != ERR_NONE) && !err_sticky_q) begin
            err_sticky_d = 1'b1;
            err_addr_d   = (err_cause == ERR_MISALIGN_I) ? iaddr : addr;
        end

        if (ld_ok && (load_count_q != '1)) begin
            load_count_d = load_count_q + 1'b1;
        end
        if (st_ok && (store_count_q != '1)) begin
            store_count_d = store_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
            err_sticky_q  <= 1'b0;
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            rvalid_q      <= rvalid_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
            err_sticky_q  <= err_sticky_d;
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
        end
    end

    assign rvalid      = rvalid_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;
    assign err_sticky  = err_sticky_q;
    assign load_count  = load_count_q;
    assign store_count = store_count_q;

endmodule
